// File: rtl/dm_access_unit_pkg.sv
// Shared memory-op codes, decoded op type and bus payload struct for the data-memory access stage.
package dm_access_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 16;

  // Store codes (same values as the main decoder's MemWrite output)
  localparam logic [1:0] MEM_SW  = 2'b01;
  localparam logic [1:0] MEM_SH  = 2'b10;
  localparam logic [1:0] MEM_SB  = 2'b11;

  // Load codes (same values as the main decoder's MemRead output)
  localparam logic [2:0] MEM_LW  = 3'b001;
  localparam logic [2:0] MEM_LH  = 3'b010;
  localparam logic [2:0] MEM_LHU = 3'b011;
  localparam logic [2:0] MEM_LB  = 3'b100;
  localparam logic [2:0] MEM_LBU = 3'b101;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_SW,
    OP_SH,
    OP_SB,
    OP_LW,
    OP_LH,
    OP_LHU,
    OP_LB,
    OP_LBU
  } mem_op_e;

  // Request payload held stable on the bus for the whole transaction
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Store wins over load; unused load codes map to no-op
  function automatic mem_op_e decode_op(input logic [1:0] mem_w, input logic [2:0] mem_r);
    mem_op_e op;
    op = OP_NONE;
    case (mem_w)
      MEM_SW: op = OP_SW;
      MEM_SH: op = OP_SH;
      MEM_SB: op = OP_SB;
      default: begin
        case (mem_r)
          MEM_LW:  op = OP_LW;
          MEM_LH:  op = OP_LH;
          MEM_LHU: op = OP_LHU;
          MEM_LB:  op = OP_LB;
          MEM_LBU: op = OP_LBU;
          default: op = OP_NONE;
        endcase
      end
    endcase
    return op;
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// Word-oriented req/ack data bus between the access stage (master) and memory (slave).
interface dm_access_unit_if;
  import dm_access_unit_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/dm_lane_align.sv
// Byte-lane steering: store enables/replication, load extraction/extension, alignment check.
module dm_lane_align
  import dm_access_unit_pkg::*;
(
  input  mem_op_e           op_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wdata_rep_o,
  output logic [DATA_W-1:0] rdata_ext_o,
  output logic              misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte / halfword out of the read word
  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo_i)
      2'd0: byte_sel = bus_rdata_i[7:0];
      2'd1: byte_sel = bus_rdata_i[15:8];
      2'd2: byte_sel = bus_rdata_i[23:16];
      2'd3: byte_sel = bus_rdata_i[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_lo_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
  end

  // Per-op lane enables, replicated store data, extended load data
  always_comb begin
    be_o         = '0;
    wdata_rep_o  = '0;
    rdata_ext_o  = '0;
    misaligned_o = 1'b0;
    case (op_i)
      OP_SW: begin
        be_o         = 4'b1111;
        wdata_rep_o  = wdata_i;
        misaligned_o = |addr_lo_i;
      end
      OP_SH: begin
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep_o  = {2{wdata_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      OP_SB: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
      end
      OP_LW: begin
        be_o         = 4'b1111;
        rdata_ext_o  = bus_rdata_i;
        misaligned_o = |addr_lo_i;
      end
      OP_LH: begin
        be_o         = 4'b1111;
        rdata_ext_o  = {{16{half_sel[15]}}, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      OP_LHU: begin
        be_o         = 4'b1111;
        rdata_ext_o  = {16'h0000, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      OP_LB: begin
        be_o        = 4'b1111;
        rdata_ext_o = {{24{byte_sel[7]}}, byte_sel};
      end
      OP_LBU: begin
        be_o        = 4'b1111;
        rdata_ext_o = {24'h000000, byte_sel};
      end
      default: begin
        be_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory access stage: aligns loads/stores, runs the bus handshake, stalls the core meanwhile.
module dm_access_unit
  import dm_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_w_i,
  input  logic [2:0]        mem_r_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  dm_access_unit_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  bus_req_t          req_q, req_d;
  mem_op_e           op_q, op_d;
  logic [1:0]        alo_q, alo_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  mem_op_e           op_live;
  mem_op_e           al_op;
  logic [1:0]        al_lo;
  logic [BE_W-1:0]   al_be;
  logic [DATA_W-1:0] al_wrep;
  logic [DATA_W-1:0] al_rext;
  logic              al_mis;

  assign op_live = decode_op(mem_w_i, mem_r_i);

  // Lane logic sees the live instruction while idle, the latched one during the transaction
  assign al_op = (state_q == ST_IDLE) ? op_live : op_q;
  assign al_lo = (state_q == ST_IDLE) ? addr_i[1:0] : alo_q;

  dm_lane_align u_lane_align (
    .op_i         (al_op),
    .addr_lo_i    (al_lo),
    .wdata_i      (wdata_i),
    .bus_rdata_i  (bus.rdata),
    .be_o         (al_be),
    .wdata_rep_o  (al_wrep),
    .rdata_ext_o  (al_rext),
    .misaligned_o (al_mis)
  );

  // State, counter and transaction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      op_q    <= OP_NONE;
      alo_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      op_q    <= op_d;
      alo_q   <= alo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic plus the combinational stall/misalign outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    op_d       = op_q;
    alo_d      = alo_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_live != OP_NONE) begin
          if (al_mis) begin
            misalign_o = 1'b1;
          end else begin
            stall_o     = 1'b1;
            req_d.we    = is_store(op_live);
            req_d.addr  = {addr_i[ADDR_W-1:2], 2'b00};
            req_d.be    = al_be;
            req_d.wdata = al_wrep;
            op_d        = op_live;
            alo_d       = addr_i[1:0];
            cnt_d       = '0;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (bus.ack) begin
          rdata_d = al_rext;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        rdata_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.req   = (state_q == ST_REQ);
  assign bus.we    = req_q.we;
  assign bus.addr  = req_q.addr;
  assign bus.be    = req_q.be;
  assign bus.wdata = req_q.wdata;

  assign rdata_o   = rdata_q;
  assign bus_err_o = err_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit: stores, loads with waits, misalignment, timeout, reset.
module tb_dm_access_unit;
  import dm_access_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  mem_w;
  logic [2:0]  mem_r;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        misalign_o;
  logic        bus_err_o;

  int checks   = 0;
  int failures = 0;

  dm_access_unit_if bus_if ();

  dm_access_unit #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_w_i    (mem_w),
    .mem_r_i    (mem_r),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .rdata_o    (rdata_o),
    .stall_o    (stall_o),
    .misalign_o (misalign_o),
    .bus_err_o  (bus_err_o),
    .bus        (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction, plays the bus slave (ack after 'waits' extra REQ cycles,
  // never if waits<0), and returns what was observed up to the first non-stalled cycle.
  task automatic run_op(input logic [1:0] w, input logic [2:0] r,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int waits,
                        output int n_stall, output int n_req,
                        output logic [3:0] be, output logic [31:0] baddr,
                        output logic [31:0] bwdata, output logic [31:0] rdo,
                        output logic we, output logic err, output logic mis);
    logic finished;
    mem_w = w; mem_r = r; addr = a; wdata = wd;
    n_stall = 0; n_req = 0; be = '0; baddr = '0; bwdata = '0;
    rdo = '0; we = 1'b0; err = 1'b0; mis = 1'b0; finished = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus_if.req) begin
        if (n_req == 0) begin
          be = bus_if.be; baddr = bus_if.addr; bwdata = bus_if.wdata; we = bus_if.we;
        end
        bus_if.ack   = (waits >= 0) && (n_req == waits);
        bus_if.rdata = rd;
        n_req++;
      end else begin
        bus_if.ack = 1'b0;
      end
      #1;
      if (!stall_o) begin
        rdo = rdata_o; err = bus_err_o; mis = misalign_o; finished = 1'b1;
        mem_w = 2'b00; mem_r = 3'b000;
        break;
      end
      n_stall++;
      @(posedge clk);
      #1;
    end
    bus_if.ack = 1'b0;
    check("op_completes", 32'(finished), 32'd1);
    step();
  endtask

  int          ns, nr;
  logic [3:0]  obe;
  logic [31:0] oaddr, owd, ord;
  logic        owe, oerr, omis;

  initial begin
    rst = 1'b1; mem_w = 2'b00; mem_r = 3'b000; addr = '0; wdata = '0;
    bus_if.ack = 1'b0; bus_if.rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_req",   32'(bus_if.req), 32'd0);
    check("rst_stall", 32'(stall_o),    32'd0);
    check("rst_rdata", rdata_o,         32'h0);
    check("rst_be",    32'(bus_if.be),  32'h0);
    check("rst_wdata", bus_if.wdata,    32'h0);
    check("rst_err",   32'(bus_err_o),  32'd0);
    step();

    // SW, ack on first REQ
    run_op(MEM_SW, 3'b000, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0, ns, nr, obe, oaddr, owd, ord, owe, oerr, omis);
    check("sw_be",    32'(obe), 32'hF);
    check("sw_addr",  oaddr,    32'h0000_0104);
    check("sw_wdata", owd,      32'hDEAD_BEEF);
    check("sw_we",    32'(owe), 32'd1);
    check("sw_stall", 32'(ns),  32'd2);
    check("sw_nreq",  32'(nr),  32'd1);
    check("sw_idle_req",   32'(bus_if.req), 32'd0);
    check("sw_idle_stall", 32'(stall_o),    32'd0);

    // SB to byte 3
    run_op(MEM_SB, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0, 0, ns, nr, obe, oaddr, owd, ord, owe, oerr, omis);
    check("sb_be",    32'(obe), 32'h8);
    check("sb_wdata", owd,      32'hA5A5_A5A5);
    check("sb_addr",  oaddr,    32'h0000_0200);

    // SH to upper half, one wait
    run_op(MEM_SH, 3'b000, 32'h0000_0012, 32'h1234_ABCD, 32'h0, 1, ns, nr, obe, oaddr, owd, ord, owe, oerr, omis);
    check("sh_be",    32'(obe), 32'hC);
    check("sh_wdata", owd,      32'hABCD_ABCD);
    check("sh_stall", 32'(ns),  32'd3);

    // LB with 3 wait cycles
    run_op(2'b00, MEM_LB, 32'h0000_0001, 32'h0, 32'h0000_8000, 3, ns, nr, obe, oaddr, owd, ord, owe, oerr, omis);
    check("lb_rdata", ord,      32'hFFFF_FF80);
    check("lb_stall", 32'(ns),  32'd5);
    check("lb_be",    32'(obe), 32'hF);
    check("lb_we",    32'(owe), 32'd0);
    check("lb_addr",  oaddr,    32'h0000_0000);
    check("lb_idle_rdata", rdata_o, 32'h0);

    run_op(2'b00, MEM_LBU, 32'h0000_0001, 32'h0, 32'h0000_8000, 3, ns, nr, obe, oaddr, owd, ord, owe, oerr, omis);
    check("lbu_rdata", ord, 32'h0000_0080);

    run_op(2'b00, MEM_LHU, 32'h0000_0002, 32'h0, 32'hBEEF_0000, 0, ns, nr, obe, oaddr, owd, ord, owe, oerr, omis);
    check("lhu_rdata", ord, 32'h0000_BEEF);

    run_op(2'b00, MEM_LH, 32'h0000_0002, 32'h0, 32'h8001_0000, 0, ns, nr, obe, oaddr, owd, ord, owe, oerr, omis);
    check("lh_rdata", ord, 32'hFFFF_8001);

    run_op(2'b00, MEM_LW, 32'h0000_0008, 32'h0, 32'h1234_5678, 2, ns, nr, obe, oaddr, owd, ord, owe, oerr, omis);
    check("lw_rdata", ord,     32'h1234_5678);
    check("lw_err",   32'(oerr), 32'd0);

    // Misaligned accesses
    run_op(2'b00, MEM_LW, 32'h0000_0006, 32'h0, 32'hFFFF_FFFF, 0, ns, nr, obe, oaddr, owd, ord, owe, oerr, omis);
    check("lwmis_pulse", 32'(omis), 32'd1);
    check("lwmis_nreq",  32'(nr),   32'd0);
    check("lwmis_stall", 32'(ns),   32'd0);
    check("lwmis_rdata", ord,       32'h0);
    check("lwmis_after", 32'(misalign_o), 32'd0);

    run_op(MEM_SH, 3'b000, 32'h0000_0001, 32'h1111_2222, 32'h0, 0, ns, nr, obe, oaddr, owd, ord, owe, oerr, omis);
    check("shmis_pulse", 32'(omis), 32'd1);
    check("shmis_nreq",  32'(nr),   32'd0);

    // Unused load code is a no-op
    run_op(2'b00, 3'b110, 32'h0000_0000, 32'h0, 32'h0, 0, ns, nr, obe, oaddr, owd, ord, owe, oerr, omis);
    check("nop_stall", 32'(ns),   32'd0);
    check("nop_mis",   32'(omis), 32'd0);
    check("nop_nreq",  32'(nr),   32'd0);

    // Ack timeout
    run_op(2'b00, MEM_LW, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, -1, ns, nr, obe, oaddr, owd, ord, owe, oerr, omis);
    check("to_nreq",  32'(nr),   32'd4);
    check("to_err",   32'(oerr), 32'd1);
    check("to_rdata", ord,       32'h0);
    check("to_stall", 32'(ns),   32'd5);
    check("to_err_after", 32'(bus_err_o), 32'd0);
    check("to_idle_req",  32'(bus_if.req), 32'd0);

    // Reset during REQ
    mem_w = 2'b00; mem_r = MEM_LW; addr = 32'h0000_0030;
    step();
    check("rstreq_req", 32'(bus_if.req), 32'd1);
    step();
    rst = 1'b1; mem_r = 3'b000;
    step();
    check("rstreq_req_off", 32'(bus_if.req), 32'd0);
    check("rstreq_stall",   32'(stall_o),    32'd0);
    rst = 1'b0;
    step();

    // Ack while idle is ignored
    bus_if.ack = 1'b1;
    step();
    check("idle_ack_req",   32'(bus_if.req), 32'd0);
    check("idle_ack_rdata", rdata_o,         32'h0);
    bus_if.ack = 1'b0;

    // Store wins when both codes are set
    run_op(MEM_SW, MEM_LW, 32'h0000_0020, 32'h0000_0055, 32'h9999_9999, 0, ns, nr, obe, oaddr, owd, ord, owe, oerr, omis);
    check("both_we",    32'(owe), 32'd1);
    check("both_be",    32'(obe), 32'hF);
    check("both_wdata", owd,      32'h0000_0055);
    check("both_rdata", ord,      32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
